// File: rtl/memoria_patron_seq.sv
// rtl/memoria_patron_seq.sv - pattern-table sequencer driving the actuator bus
// Plays table entries 0..last for max(dwell,1) ticks each, once or looping.
module memoria_patron_seq #(
  parameter int               WIDTH    = 11,
  parameter int               DEPTH    = 4,
  parameter int               DWELL_W  = 8,
  parameter logic [WIDTH-1:0] IDLE_PAT = {WIDTH{1'b1}},
  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               tick_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               loop_i,
  input  logic [AW-1:0]      last_idx_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [WIDTH-1:0]   wr_pat_i,
  input  logic [DWELL_W-1:0] wr_dwell_i,
  output logic [WIDTH-1:0]   salida_o,
  output logic [AW-1:0]      idx_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     salida_q;
  logic [AW-1:0]        idx_q;
  logic                 busy_q;
  logic                 done_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic [AW-1:0]        last_q;
  logic [WIDTH-1:0]     pat_q   [DEPTH];
  logic [DWELL_W-1:0]   dwell_q [DEPTH];

  logic [AW-1:0]        idx_inc_d;
  logic [AW-1:0]        last_d;

  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  always_comb begin
    idx_inc_d = idx_q + AW'(1);
    last_d    = (last_idx_i > LAST_MAX) ? LAST_MAX : last_idx_i;
  end

  // Table writes use non-blocking updates, so a same-cycle load sees the old entry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i]   <= IDLE_PAT;
        dwell_q[i] <= DWELL_W'(1);
      end
    end else if (wr_en_i && (wr_addr_i <= LAST_MAX)) begin
      pat_q[wr_addr_i]   <= wr_pat_i;
      dwell_q[wr_addr_i] <= wr_dwell_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      salida_q <= IDLE_PAT;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && !stop_i) begin
            state_q  <= S_RUN;
            idx_q    <= '0;
            salida_q <= pat_q[0];
            cnt_q    <= eff_dwell(dwell_q[0]);
            busy_q   <= 1'b1;
            last_q   <= last_d;
          end
        end
        S_RUN: begin
          if (stop_i) begin
            state_q  <= S_IDLE;
            salida_q <= IDLE_PAT;
            idx_q    <= '0;
            busy_q   <= 1'b0;
          end else if (tick_i) begin
            if (cnt_q > DWELL_W'(1)) begin
              cnt_q <= cnt_q - DWELL_W'(1);
            end else if (idx_q != last_q) begin
              idx_q    <= idx_inc_d;
              salida_q <= pat_q[idx_inc_d];
              cnt_q    <= eff_dwell(dwell_q[idx_inc_d]);
            end else if (loop_i) begin
              idx_q    <= '0;
              salida_q <= pat_q[0];
              cnt_q    <= eff_dwell(dwell_q[0]);
            end else begin
              state_q  <= S_IDLE;
              salida_q <= IDLE_PAT;
              idx_q    <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign salida_o = salida_q;
  assign idx_o    = idx_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_memoria_patron_seq.sv
// tb/tb_memoria_patron_seq.sv - scoreboard bench for memoria_patron_seq
// A tick-counting playback model predicts every cycle; a monitor compares at negedge.
module tb_memoria_patron_seq;

  localparam logic [10:0] IDLE = 11'h7FF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [1:0]  last_idx = '0, wr_addr = '0;
  logic        wr_en = 1'b0;
  logic [10:0] wr_pat = '0;
  logic [7:0]  wr_dwell = '0;
  logic [10:0] salida;
  logic [1:0]  idx;
  logic        busy, done;

  logic        start2 = 1'b0, one = 1'b1, zero = 1'b0;
  logic [1:0]  last2 = 2'd3, addr2 = '0;
  logic [10:0] pat2 = '0;
  logic [7:0]  dw2 = '0;
  logic [10:0] salida2;
  logic [1:0]  idx2;
  logic        busy2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memoria_patron_seq #(.WIDTH(11), .DEPTH(4), .DWELL_W(8), .IDLE_PAT(11'h7FF)) dut (
    .clk_i(clk), .reset_i(reset), .tick_i(tick), .start_i(start), .stop_i(stop),
    .loop_i(loop), .last_idx_i(last_idx), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_pat_i(wr_pat), .wr_dwell_i(wr_dwell), .salida_o(salida), .idx_o(idx),
    .busy_o(busy), .done_o(done));

  memoria_patron_seq #(.WIDTH(11), .DEPTH(3), .DWELL_W(8), .IDLE_PAT(11'h7FF)) dut3 (
    .clk_i(clk), .reset_i(reset), .tick_i(one), .start_i(start2), .stop_i(zero),
    .loop_i(zero), .last_idx_i(last2), .wr_en_i(zero), .wr_addr_i(addr2),
    .wr_pat_i(pat2), .wr_dwell_i(dw2), .salida_o(salida2), .idx_o(idx2),
    .busy_o(busy2), .done_o(done2));

  typedef struct packed {
    logic [10:0] sal;
    logic [1:0]  idx;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: table contents, plus the entry being shown and how many ticks it has had.
  logic [10:0] m_pat [4];
  int          m_dw  [4];
  bit          m_run = 0, m_done = 0;
  int          m_e = 0, m_el = 0, m_hold = 1, m_last = 0;
  logic [10:0] m_sal = IDLE;

  task automatic enter(input int k);
    m_e    = k;
    m_el   = 0;
    m_sal  = m_pat[k];
    m_hold = (m_dw[k] == 0) ? 1 : m_dw[k];
  endtask

  task automatic model_update();
    exp_t e;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_pat[i] = IDLE;
        m_dw[i]  = 1;
      end
      m_run = 0; m_done = 0; m_e = 0; m_last = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run  = 1;
          m_last = (int'(last_idx) > 3) ? 3 : int'(last_idx);
          enter(0);
        end
      end else if (stop) begin
        m_run = 0;
        m_e   = 0;
      end else if (tick) begin
        m_el++;
        if (m_el >= m_hold) begin
          if (m_e != m_last) enter(m_e + 1);
          else if (loop) enter(0);
          else begin
            m_run  = 0;
            m_e    = 0;
            m_done = 1;
          end
        end
      end
      if (wr_en) begin
        m_pat[wr_addr] = wr_pat;
        m_dw[wr_addr]  = int'(wr_dwell);
      end
    end
    e.sal  = m_run ? m_sal : IDLE;
    e.idx  = 2'(m_e);
    e.busy = m_run;
    e.done = m_done;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("sb_outputs", {17'd0, salida, idx, busy, done}, {17'd0, e});
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start(input logic [1:0] l, input logic lp);
    last_idx = l;
    loop     = lp;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [10:0] p, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_pat = p; wr_dwell = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(1);
    // Untouched table: all entries idle pattern, dwell 1.
    pulse_start(2'd3, 1'b0);
    cyc(6);

    wr(2'd0, 11'b11010001000, 8'd2);
    wr(2'd1, 11'h001, 8'd1);
    pulse_start(2'd1, 1'b0);
    cyc(5);

    pulse_start(2'd1, 1'b1);
    cyc(9);
    loop = 1'b0;
    cyc(6);

    // Abort with stop and tick together mid-e0.
    pulse_start(2'd1, 1'b0);
    stop = 1'b1; tick = 1'b1;
    step();
    stop = 1'b0;
    cyc(2);

    // Async reset mid-run, observed before the next clock edge.
    pulse_start(2'd1, 1'b1);
    cyc(1);
    #6;
    reset = 1'b1;
    #1;
    chk("async_rst_salida", {21'd0, salida}, {21'd0, IDLE});
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_idx", {30'd0, idx}, 32'd0);
    step();
    reset = 1'b0;
    cyc(1);

    wr(2'd0, 11'h688, 8'd2);
    wr(2'd1, 11'h001, 8'd1);
    wr(2'd2, 11'h155, 8'd0);
    wr(2'd3, 11'h2AA, 8'd3);
    pulse_start(2'd3, 1'b0);
    cyc(10);

    // Rewrite e0 while it is driven; new value appears only on the next wrap.
    wr(2'd0, 11'h3C3, 8'd3);
    pulse_start(2'd3, 1'b1);
    wr(2'd0, 11'h0F0, 8'd2);
    cyc(14);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Tick every third clock with dwell 2; also start while running is ignored.
    wr(2'd0, 11'h0AB, 8'd2);
    tick = 1'b0;
    pulse_start(2'd1, 1'b1);
    for (int c = 0; c < 15; c++) begin
      tick  = (c % 3 == 0);
      start = (c == 4);
      step();
    end
    start = 1'b0;
    tick  = 1'b1;
    loop  = 1'b0;
    cyc(8);

    for (int c = 0; c < 400; c++) begin
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      tick     = ($urandom_range(0, 3) != 0);
      loop     = ($urandom_range(0, 3) != 0);
      last_idx = 2'($urandom_range(0, 3));
      wr_en    = ($urandom_range(0, 4) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_pat   = 11'($urandom);
      wr_dwell = 8'($urandom_range(0, 3));
      step();
    end
    start = 1'b0; stop = 1'b1; wr_en = 1'b0;
    step();
    stop = 1'b0;
    cyc(2);
    @(negedge clk);
    #1;
    chk("sb_drained", sbq.size(), 32'd0);

    // Three-entry instance: last_idx=3 must clamp to entry 2.
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("clamp_idx", {30'd0, idx2}, k);
      chk("clamp_busy", {31'd0, busy2}, 32'd1);
      @(posedge clk);
      #1;
    end
    chk("clamp_done", {31'd0, done2}, 32'd1);
    chk("clamp_idle", {31'd0, busy2}, 32'd0);
    chk("clamp_salida", {21'd0, salida2}, {21'd0, IDLE});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
